uart_tx_fifo_param: RTL and testbench
=====================================

Name: uart_tx_fifo_param

Overview:
Parametrised UART transmitter with an integrated transmit FIFO and an internal baud divider, all on one system clock.
- Frame format is selectable per frame: data width, parity mode and stop-bit count.
- Sits between a host-side valid/ready byte stream and the serial TxD pin.
- Replaces the fixed 8N1, separate-TxC transmitter.

Parameters:
- DATA_W, 8, data bits per frame (5..9); FIFO word width.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, >=2.
- CLK_DIV, 16, clk cycles per serial bit (>=2).
- CNT_W, $clog2(FIFO_DEPTH+1), width of fifo_count.

Ports:
- clk, input, 1, system clock; all logic on posedge.
- resetn, input, 1, asynchronous active-low reset.
- din, input, DATA_W, transmit data word.
- din_valid, input, 1, host offers din.
- din_ready, output, 1, FIFO not full; a push occurs when din_valid & din_ready.
- parity_mode, input, 2, 00 none, 01 even, 10 odd, 11 none.
- two_stop, input, 1, 1 = two stop bits, 0 = one.
- clr_err, input, 1, clears err_ovf.
- TxD, output, 1, serial out; registered; idles high.
- busy, output, 1, FSM not in IDLE.
- TE, output, 1, FIFO empty and FSM idle (all data sent).
- fifo_count, output, CNT_W, number of words queued.
- err_ovf, output, 1, sticky; set when din_valid & ~din_ready.

Behaviour:
- Reset (async, resetn=0):
  - Outputs: TxD=1, din_ready=1, busy=0, TE=1, fifo_count=0, err_ovf=0.
  - FSM goes to IDLE and the divider clears.
  - Reset mid-frame aborts the frame immediately; TxD returns high asynchronously and the FIFO contents are discarded.
- FIFO:
  - Push on din_valid & din_ready; pop by the FSM only.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Push while full is dropped; the FIFO is unchanged and err_ovf sets.
  - clr_err clears err_ovf; if clr_err and an overflow occur in the same cycle, the set wins.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TxD=1. If the FIFO is non-empty, pop the head into the shift register, latch parity_mode/two_stop into frame config, clear the divider and bit counter, and go to START.
  - START: TxD=0 for CLK_DIV cycles, then DATA.
  - DATA: TxD=shift[0], LSB first. Shift right every CLK_DIV cycles. After DATA_W bits, go to PARITY if parity is enabled, else STOP.
  - PARITY: TxD = XOR of the data bits (even mode) or its inverse (odd mode) for CLK_DIV cycles, then STOP.
  - STOP: TxD=1 for CLK_DIV cycles (2*CLK_DIV if two_stop is latched).
  - End of STOP: if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Timing:
  - Divider counts 0..CLK_DIV-1 and wraps; a bit boundary occurs at wrap.
  - Latency: a word pushed at edge t into an empty FIFO with the FSM idle is popped at edge t+1. TxD falls at edge t+2.
  - Frame length = CLK_DIV*(1 + DATA_W + P + S), where P = parity enabled (0/1) and S = 1 or 2.
- Config: parity_mode/two_stop changes mid-frame do not affect the current frame.
- Status outputs: busy=1 from the pop edge until the cycle IDLE is re-entered. TE = (fifo_count==0) & ~busy; registered or equivalent-glitch-free.
- Arithmetic: bit counter width $clog2(DATA_W+1); FIFO pointers $clog2(FIFO_DEPTH) bits, wrapping naturally.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding.
  - Parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD.
  - Helper function for parity of a DATA_W vector.
- Sub-module uart_sync_fifo: synchronous FIFO with parameters width and depth.
  - Ports: push, pop, full, empty, count, and head data (show-ahead).
  - Reusable by the future receiver.
- Top level holds the baud divider, FSM and shift register.

Test Plan:
1. CLK_DIV=4, DATA_W=8, parity 00, two_stop=0, push 0x55 -> TxD low from edge t+2. Over 40 clk it shows bits 0,1,0,1,0,1,0,1,0,1 with 4 clk each. TE returns to 1 after the stop bit.
2. Same config, parity 01, push 0x07 -> parity bit=1; frame 44 clk. Parity 10 with the same data -> parity bit=0.
3. two_stop=1, push 0xA3 -> stop high for 8 clk. Toggling two_stop mid-frame leaves the frame at 44 clk; the next frame uses the new value.
4. FIFO_DEPTH=4, push 5 words back-to-back while idle:
   - First word is popped at t+1, so words 2-5 fill the FIFO and din_ready=0 after the 5th push.
   - A 6th push sets err_ovf=1 and the FIFO is unchanged.
   - All 5 frames go out with no idle gap between stop and start.
5. Push 0xFF, assert resetn=0 mid-DATA -> TxD=1, busy=0, TE=1, fifo_count=0 immediately. After release, no residual frame is sent.
6. DATA_W=7 build, push 0x41 with even parity -> 7 data bits LSB first, parity=0, frame 40 clk at CLK_DIV=4.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : shared UART types, parity constants and parity helper.
// Rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int MAX_DATA_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_of(input logic [MAX_DATA_W-1:0] v);
    return ^v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_sync_fifo : show-ahead synchronous FIFO, power-of-two depth.
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  import uart_pkg::*;

  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (count_q == C_DEPTH);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers are exactly log2(DEPTH) wide so they wrap without compare logic.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_fifo_param : UART transmitter with TX FIFO, baud divider, per-frame format.
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_fifo_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  input  logic              clr_err,
  output logic              TxD,
  output logic              busy,
  output logic              TE,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              err_ovf
);
  import uart_pkg::*;

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(DATA_W - 1);

  tx_state_e         state_q;
  logic [DIV_W-1:0]  div_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_en_q;
  logic              par_bit_q;
  logic              two_stop_q;
  logic              txd_q;
  logic              busy_q;
  logic              te_q;
  logic              err_q;

  logic [DATA_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_tick;
  logic              w_stop_done;
  logic              w_busy_d;
  logic [CNT_W-1:0]  w_cnt_d;

  assign din_ready = ~w_full;
  assign w_push    = din_valid & din_ready;

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (din),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (fifo_count)
  );

  assign w_tick      = (div_q == C_DIV_LAST);
  // In STOP the bit counter marks the first of two stop bits.
  assign w_stop_done = (state_q == ST_STOP) && w_tick && (!two_stop_q || (bit_cnt_q != '0));
  assign w_pop       = ~w_empty && ((state_q == ST_IDLE) || w_stop_done);
  assign w_busy_d    = w_pop || (busy_q && !w_stop_done);
  assign w_cnt_d     = fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      te_q       <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      busy_q <= w_busy_d;
      te_q   <= (w_cnt_d == '0) && !w_busy_d;

      if (din_valid && !din_ready) begin
        err_q <= 1'b1;
      end else if (clr_err) begin
        err_q <= 1'b0;
      end

      // The line follows the state one cycle late, so the start bit leaves two edges after the push.
      unique case (state_q)
        ST_START:  txd_q <= 1'b0;
        ST_DATA:   txd_q <= shift_q[0];
        ST_PARITY: txd_q <= par_bit_q;
        default:   txd_q <= 1'b1;
      endcase

      div_q <= w_tick ? '0 : div_q + DIV_W'(1);

      if (w_pop) begin
        shift_q    <= w_head;
        par_en_q   <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
        par_bit_q  <= parity_of(MAX_DATA_W'(w_head)) ^ (parity_mode == PAR_ODD);
        two_stop_q <= two_stop;
        div_q      <= '0;
        bit_cnt_q  <= '0;
        state_q    <= ST_START;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            div_q <= '0;
          end
          ST_START: begin
            if (w_tick) begin
              state_q <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (w_tick) begin
              shift_q <= shift_q >> 1;
              if (bit_cnt_q == C_BIT_LAST) begin
                bit_cnt_q <= '0;
                state_q   <= par_en_q ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              end
            end
          end
          ST_PARITY: begin
            if (w_tick) begin
              state_q <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (w_stop_done) begin
              state_q <= ST_IDLE;
            end else if (w_tick) begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign TxD     = txd_q;
  assign busy    = busy_q;
  assign TE      = te_q;
  assign err_ovf = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo_param : directed bench for 8-bit and 7-bit builds at CLK_DIV=4.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       clr_err;

  logic [7:0] din8;
  logic       val8, ready8, txd8, busy8, te8, err8;
  logic [2:0] cnt8;

  logic [6:0] din7;
  logic       val7, ready7, txd7, busy7, te7, err7;
  logic [2:0] cnt7;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_fifo_param #(.DATA_W(8), .FIFO_DEPTH(4), .CLK_DIV(4)) u_dut8 (
    .clk(clk), .resetn(resetn), .din(din8), .din_valid(val8), .din_ready(ready8),
    .parity_mode(parity_mode), .two_stop(two_stop), .clr_err(clr_err),
    .TxD(txd8), .busy(busy8), .TE(te8), .fifo_count(cnt8), .err_ovf(err8)
  );

  uart_tx_fifo_param #(.DATA_W(7), .FIFO_DEPTH(4), .CLK_DIV(4)) u_dut7 (
    .clk(clk), .resetn(resetn), .din(din7), .din_valid(val7), .din_ready(ready7),
    .parity_mode(parity_mode), .two_stop(two_stop), .clr_err(clr_err),
    .TxD(txd7), .busy(busy7), .TE(te7), .fifo_count(cnt7), .err_ovf(err7)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push8(input logic [7:0] d);
    din8 = d;
    val8 = 1'b1;
    @(negedge clk);
    val8 = 1'b0;
  endtask

  // Entered on the first negedge of the start bit; leaves on the negedge one frame later.
  task automatic check_frame(input bit use7, input logic [8:0] data, input logic [1:0] pm, input bit ts);
    logic [12:0] bits;
    int          n;
    int          dw;
    logic        p;
    bits = '0;
    dw   = use7 ? 7 : 8;
    p    = 1'b0;
    n    = 1;
    for (int i = 0; i < dw; i++) begin
      bits[n] = data[i];
      p       = p ^ data[i];
      n++;
    end
    if (pm == 2'b01) begin
      bits[n] = p;
      n++;
    end else if (pm == 2'b10) begin
      bits[n] = ~p;
      n++;
    end
    bits[n] = 1'b1;
    n++;
    if (ts) begin
      bits[n] = 1'b1;
      n++;
    end
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("txd d=%0h bit%0d/%0d", data, i, k), use7 ? txd7 : txd8, bits[i]);
        if (i == n - 1 && k == 2) begin
          chk("busy_last_stop", use7 ? busy7 : busy8, 1'b1);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    logic [7:0] words [5];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h93;
    words[3] = 8'hC4; words[4] = 8'h5A;

    resetn = 1'b0; parity_mode = 2'b00; two_stop = 1'b0; clr_err = 1'b0;
    din8 = '0; val8 = 1'b0; din7 = '0; val7 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd8, 1'b1);
    chk("rst_ready", ready8, 1'b1);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_te", te8, 1'b1);
    chk("rst_cnt", cnt8, 3'd0);
    chk("rst_err", err8, 1'b0);
    chk("rst_txd7", txd7, 1'b1);
    resetn = 1'b1;
    @(negedge clk);

    // 8N1 with exact push-to-start latency
    push8(8'h55);
    chk("te_after_push", te8, 1'b0);
    chk("cnt_after_push", cnt8, 3'd1);
    chk("busy_before_pop", busy8, 1'b0);
    @(negedge clk);
    chk("txd_at_pop", txd8, 1'b1);
    chk("busy_at_pop", busy8, 1'b1);
    chk("cnt_at_pop", cnt8, 3'd0);
    @(negedge clk);
    check_frame(0, 9'h055, 2'b00, 1'b0);
    chk("busy_end_8n1", busy8, 1'b0);
    chk("te_end_8n1", te8, 1'b1);

    // Even then odd parity
    parity_mode = 2'b01;
    push8(8'h07); @(negedge clk); @(negedge clk);
    check_frame(0, 9'h007, 2'b01, 1'b0);
    chk("te_end_even", te8, 1'b1);
    parity_mode = 2'b10;
    push8(8'h07); @(negedge clk); @(negedge clk);
    check_frame(0, 9'h007, 2'b10, 1'b0);
    chk("te_end_odd", te8, 1'b1);

    // Two stop bits, then config changed after the pop
    parity_mode = 2'b00;
    two_stop    = 1'b1;
    push8(8'hA3); @(negedge clk); @(negedge clk);
    check_frame(0, 9'h0A3, 2'b00, 1'b1);
    chk("te_end_2stop", te8, 1'b1);
    push8(8'h3C); @(negedge clk);
    two_stop    = 1'b0;
    parity_mode = 2'b01;
    @(negedge clk);
    check_frame(0, 9'h03C, 2'b00, 1'b1);
    chk("te_end_latched", te8, 1'b1);
    push8(8'h3C); @(negedge clk); @(negedge clk);
    check_frame(0, 9'h03C, 2'b01, 1'b0);
    chk("te_end_newcfg", te8, 1'b1);
    parity_mode = 2'b00;

    // Fill FIFO, overflow, clear, and five back-to-back frames
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          din8 = words[i];
          val8 = 1'b1;
          @(negedge clk);
        end
        chk("full_ready", ready8, 1'b0);
        chk("full_cnt", cnt8, 3'd4);
        chk("full_err0", err8, 1'b0);
        din8 = 8'hEE;
        @(negedge clk);
        chk("ovf_err", err8, 1'b1);
        chk("ovf_cnt", cnt8, 3'd4);
        clr_err = 1'b1;
        @(negedge clk);
        chk("ovf_set_wins", err8, 1'b1);
        val8 = 1'b0;
        @(negedge clk);
        chk("clr_err", err8, 1'b0);
        clr_err = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          check_frame(0, {1'b0, words[i]}, 2'b00, 1'b0);
        end
      end
    join
    chk("b2b_busy_end", busy8, 1'b0);
    chk("b2b_te_end", te8, 1'b1);
    chk("b2b_cnt_end", cnt8, 3'd0);

    // Reset in the middle of the data bits
    push8(8'hFF);
    push8(8'h12);
    repeat (14) @(negedge clk);
    chk("pre_rst_busy", busy8, 1'b1);
    chk("pre_rst_cnt", cnt8, 3'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_txd", txd8, 1'b1);
    chk("mid_rst_busy", busy8, 1'b0);
    chk("mid_rst_te", te8, 1'b1);
    chk("mid_rst_cnt", cnt8, 3'd0);
    chk("mid_rst_ready", ready8, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (txd8 !== 1'b1) lows++;
    end
    chk("no_residual_frame", lows, 0);
    chk("post_rst_busy", busy8, 1'b0);

    // 7-bit build, even parity
    parity_mode = 2'b01;
    din7 = 7'h41;
    val7 = 1'b1;
    @(negedge clk);
    val7 = 1'b0;
    chk("dw7_cnt", cnt7, 3'd1);
    @(negedge clk); @(negedge clk);
    check_frame(1, 9'h041, 2'b01, 1'b0);
    chk("dw7_busy_end", busy7, 1'b0);
    chk("dw7_te_end", te7, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
